// File: rtl/halfadder_db.sv
// rtl/halfadder_db.sv - half adder with registered shadow outputs, coverage and saturating counters
// Optional self-check output err is enabled by defining HALFADDER_DB_CHECK_EN.
module halfadder_db #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             x,
    input  logic             y,
    output logic             sum,
    output logic             carry,
    output logic             sum_q,
    output logic             carry_q,
    output logic [3:0]       seen,
    output logic [CNT_W-1:0] carry_cnt,
    output logic [CNT_W-1:0] sum_cnt,
`ifdef HALFADDER_DB_CHECK_EN
    output logic             err,
`endif
    output logic             all_seen
);

    logic [3:0] seen_next;

    // Combinational path stays live with the clock idle and during reset.
    assign sum   = x ^ y;
    assign carry = x & y;

    always_comb begin
        seen_next = seen;
        seen_next[{x, y}] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sum_q     <= 1'b0;
            carry_q   <= 1'b0;
            seen      <= 4'b0000;
            all_seen  <= 1'b0;
            carry_cnt <= '0;
            sum_cnt   <= '0;
        end else begin
            sum_q    <= sum;
            carry_q  <= carry;
            seen     <= seen_next;
            all_seen <= &seen_next;
            if (carry && (carry_cnt != {CNT_W{1'b1}}))
                carry_cnt <= carry_cnt + 1'b1;
            if (sum && (sum_cnt != {CNT_W{1'b1}}))
                sum_cnt <= sum_cnt + 1'b1;
        end
    end

`ifdef HALFADDER_DB_CHECK_EN
    logic x_c;
    logic y_c;

    // Independent copy of the operands; sum_q/carry_q must always match a recompute from it.
    always_ff @(posedge clk) begin
        if (rst) begin
            x_c <= 1'b0;
            y_c <= 1'b0;
            err <= 1'b0;
        end else begin
            x_c <= x;
            y_c <= y;
            if ((sum_q != (x_c ^ y_c)) || (carry_q != (x_c & y_c)) || (sum_q & carry_q))
                err <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_halfadder_db.sv
// tb/tb_halfadder_db.sv - table-driven self-checking bench for halfadder_db
module tb_halfadder_db;

    logic clk = 1'b0;
    logic clk_en = 1'b0;
    logic rst = 1'b0;
    logic x = 1'b0, y = 1'b0;
    logic x2 = 1'b0, y2 = 1'b0;

    logic       sum, carry, sum_q, carry_q, all_seen;
    logic [3:0] seen;
    logic [7:0] carry_cnt, sum_cnt;
    logic       sum2, carry2, sum_q2, carry_q2, all_seen2;
    logic [3:0] seen2;
    logic [1:0] carry_cnt2, sum_cnt2;
`ifdef HALFADDER_DB_CHECK_EN
    logic err, err2;
`endif

    int checks = 0;
    int errors = 0;

    always #5 if (clk_en) clk = ~clk; else clk = 1'b0;

    halfadder_db #(.CNT_W(8)) dut (
        .clk(clk), .rst(rst), .x(x), .y(y),
        .sum(sum), .carry(carry), .sum_q(sum_q), .carry_q(carry_q),
        .seen(seen), .carry_cnt(carry_cnt), .sum_cnt(sum_cnt),
`ifdef HALFADDER_DB_CHECK_EN
        .err(err),
`endif
        .all_seen(all_seen)
    );

    halfadder_db #(.CNT_W(2)) dut2 (
        .clk(clk), .rst(rst), .x(x2), .y(y2),
        .sum(sum2), .carry(carry2), .sum_q(sum_q2), .carry_q(carry_q2),
        .seen(seen2), .carry_cnt(carry_cnt2), .sum_cnt(sum_cnt2),
`ifdef HALFADDER_DB_CHECK_EN
        .err(err2),
`endif
        .all_seen(all_seen2)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic       x, y;
        logic       exp_sum, exp_carry;
        logic [3:0] exp_seen;
        logic       exp_all;
        logic [7:0] exp_scnt, exp_ccnt;
    } vec_t;

    vec_t vecs[4];
    logic [1:0] sat_exp[6];

    initial begin
        vecs[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 4'b0001, 1'b0, 8'd0, 8'd0};
        vecs[1] = '{1'b0, 1'b1, 1'b1, 1'b0, 4'b0011, 1'b0, 8'd1, 8'd0};
        vecs[2] = '{1'b1, 1'b0, 1'b1, 1'b0, 4'b0111, 1'b0, 8'd2, 8'd0};
        vecs[3] = '{1'b1, 1'b1, 1'b0, 1'b1, 4'b1111, 1'b1, 8'd2, 8'd1};
        sat_exp = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3, 2'd3};

        // Combinational sweep with the clock stopped
        for (int i = 0; i < 4; i++) begin
            x = vecs[i].x;
            y = vecs[i].y;
            #1;
            check($sformatf("comb_sum[%0d]", i), sum, vecs[i].exp_sum);
            check($sformatf("comb_carry[%0d]", i), carry, vecs[i].exp_carry);
            #9;
        end

        // Reset for two edges with x=y=1
        x = 1'b1; y = 1'b1; rst = 1'b1;
        clk_en = 1'b1;
        tick(); tick();
        check("rst_sum_q", sum_q, 1'b0);
        check("rst_carry_q", carry_q, 1'b0);
        check("rst_seen", seen, 4'b0000);
        check("rst_all_seen", all_seen, 1'b0);
        check("rst_carry_cnt", carry_cnt, 8'd0);
        check("rst_sum_cnt", sum_cnt, 8'd0);
        check("rst_comb_carry", carry, 1'b1);
        check("rst_comb_sum", sum, 1'b0);
        check("rst_cnt2", carry_cnt2, 2'd0);
        rst = 1'b0;

        // Walk the four input pairs, one per edge
        for (int i = 0; i < 4; i++) begin
            x = vecs[i].x;
            y = vecs[i].y;
            #1;
            check($sformatf("lag_sum_q[%0d]", i), sum_q, (i == 0) ? 1'b0 : vecs[i-1].exp_sum);
            tick();
            check($sformatf("sum_q[%0d]", i), sum_q, vecs[i].exp_sum);
            check($sformatf("carry_q[%0d]", i), carry_q, vecs[i].exp_carry);
            check($sformatf("seen[%0d]", i), seen, vecs[i].exp_seen);
            check($sformatf("all_seen[%0d]", i), all_seen, vecs[i].exp_all);
            check($sformatf("sum_cnt[%0d]", i), sum_cnt, vecs[i].exp_scnt);
            check($sformatf("carry_cnt[%0d]", i), carry_cnt, vecs[i].exp_ccnt);
        end

        // CNT_W=2 saturation on the second instance
        x2 = 1'b1; y2 = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            check($sformatf("sat_carry_cnt[%0d]", i), carry_cnt2, sat_exp[i]);
            check($sformatf("sat_sum_cnt[%0d]", i), sum_cnt2, 2'd0);
        end
        check("sat_sum_q_carry_q_excl", sum_q2 & carry_q2, 1'b0);
        x2 = 1'b0; y2 = 1'b0;

        // Mid-sequence reset after seen=0111
        rst = 1'b1; tick(); rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            x = vecs[i].x; y = vecs[i].y;
            tick();
        end
        check("mid_seen_before", seen, 4'b0111);
        x = 1'b1; y = 1'b1; rst = 1'b1;
        tick();
        check("mid_seen", seen, 4'b0000);
        check("mid_all_seen", all_seen, 1'b0);
        check("mid_sum_cnt", sum_cnt, 8'd0);
        check("mid_carry_cnt", carry_cnt, 8'd0);
        check("mid_carry_q", carry_q, 1'b0);
        rst = 1'b0; x = 1'b0; y = 1'b1;
        tick();
        check("restart_sum_cnt", sum_cnt, 8'd1);
        check("restart_carry_cnt", carry_cnt, 8'd0);
        check("restart_seen", seen, 4'b0010);
        check("restart_sum_q", sum_q, 1'b1);

`ifdef HALFADDER_DB_CHECK_EN
        rst = 1'b1; tick(); rst = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            logic px, py;
            px = 1'($urandom_range(0, 1));
            py = 1'($urandom_range(0, 1));
            x = px; y = py;
            tick();
            if (sum_q !== (px ^ py) || carry_q !== (px & py))
                check("rand_regs", {sum_q, carry_q}, {px ^ py, px & py});
        end
        check("rand_err", err, 1'b0);
        check("rand_err2", err2, 1'b0);
        x = 1'b0; y = 1'b0;
        tick();
        force dut.sum_q = 1'b1;
        tick();
        release dut.sum_q;
        check("force_err", err, 1'b1);
        tick(); tick();
        check("err_sticky", err, 1'b1);
        rst = 1'b1; tick(); rst = 1'b0;
        check("err_cleared", err, 1'b0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
